mdu_seq: RTL

MDU_SEQ -- requirements
Module: mdu_seq

---
 rtl/mdu_defs.sv | 30 +++
 rtl/mdu_seq_if.sv | 26 ++
 rtl/mdu_calc.sv | 43 ++++
 rtl/mdu_seq.sv | 111 +++++++++++
 4 files changed

// File: rtl/mdu_defs.sv
// Shared MDU definitions: operation codes, default latencies and FSM state encoding.
package mdu_defs;

  localparam logic [4:0] OP_NONE  = 5'd0;
  localparam logic [4:0] OP_MULT  = 5'd1;
  localparam logic [4:0] OP_MULTU = 5'd2;
  localparam logic [4:0] OP_DIV   = 5'd3;
  localparam logic [4:0] OP_DIVU  = 5'd4;
  localparam logic [4:0] OP_MFHI  = 5'd5;
  localparam logic [4:0] OP_MFLO  = 5'd6;
  localparam logic [4:0] OP_MTHI  = 5'd7;
  localparam logic [4:0] OP_MTLO  = 5'd8;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_mult(input logic [4:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// E-stage pipeline <-> MDU signal bundle.
// Handshake: start is a single-cycle request taken only in IDLE with flush low;
// busy high means further start/mthi/mtlo are dropped until it falls.
interface mdu_seq_if;
  logic [4:0]  MDU_op;
  logic        start;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        D_is_mdu;
  logic        busy;
  logic        stall_req;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] rd_data;

  modport master (
    output MDU_op, start, rs_val, rt_val, flush, D_is_mdu,
    input  busy, stall_req, HI, LO, rd_data
  );

  modport slave (
    input  MDU_op, start, rs_val, rt_val, flush, D_is_mdu,
    output busy, stall_req, HI, LO, rd_data
  );
endinterface

// File: rtl/mdu_calc.sv
// Purely combinational multiply/divide datapath producing the HI/LO pair.
module mdu_calc
  import mdu_defs::*;
(
  input  logic [4:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        wr_en
);

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        b_safe;
  logic signed [31:0] q_s;
  logic signed [31:0] r_s;
  logic [31:0]        q_u;
  logic [31:0]        r_u;

  // Divide by a substitute 1 when b==0 so nothing goes X; wr_en suppresses the write.
  assign b_safe = (b == 32'd0) ? 32'd1 : b;
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};
  assign q_s    = $signed(a) / $signed(b_safe);
  assign r_s    = $signed(a) % $signed(b_safe);
  assign q_u    = a / b_safe;
  assign r_u    = a % b_safe;

  always_comb begin
    hi    = 32'd0;
    lo    = 32'd0;
    wr_en = 1'b0;
    case (op)
      OP_MULT:  begin hi = prod_s[63:32]; lo = prod_s[31:0]; wr_en = 1'b1; end
      OP_MULTU: begin hi = prod_u[63:32]; lo = prod_u[31:0]; wr_en = 1'b1; end
      OP_DIV:   begin hi = r_s;           lo = q_s;          wr_en = (b != 32'd0); end
      OP_DIVU:  begin hi = r_u;           lo = q_u;          wr_en = (b != 32'd0); end
      default:  ;
    endcase
  end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle MIPS-style MDU: computes up front, holds busy for a fixed latency, then commits HI/LO.
module mdu_seq
  import mdu_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  MDU_op,
  input  logic        start,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  input  logic        D_is_mdu,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] rd_data,
  output state_t      dbg_state
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [31:0]   pend_hi, pend_hi_n, pend_lo, pend_lo_n;
  logic          pend_ok, pend_ok_n;
  logic [31:0]   hi_n, lo_n;
  logic [31:0]   calc_hi, calc_lo;
  logic          calc_wr;

  mdu_calc u_calc (
    .op    (MDU_op),
    .a     (rs_val),
    .b     (rt_val),
    .hi    (calc_hi),
    .lo    (calc_lo),
    .wr_en (calc_wr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_ok <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pend_hi <= pend_hi_n;
      pend_lo <= pend_lo_n;
      pend_ok <= pend_ok_n;
      HI      <= hi_n;
      LO      <= lo_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pend_hi_n = pend_hi;
    pend_lo_n = pend_lo;
    pend_ok_n = pend_ok;
    hi_n      = HI;
    lo_n      = LO;
    case (state)
      ST_IDLE: begin
        if (!flush) begin
          if (start && is_muldiv(MDU_op)) begin
            pend_hi_n = calc_hi;
            pend_lo_n = calc_lo;
            pend_ok_n = calc_wr;
            cnt_n     = is_mult(MDU_op) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            state_n   = ST_BUSY;
          end else if (MDU_op == OP_MTHI) begin
            hi_n = rs_val;
          end else if (MDU_op == OP_MTLO) begin
            lo_n = rs_val;
          end
        end
      end
      ST_BUSY: begin
        // Flush, start and mt* are all ignored here; only the countdown matters.
        if (cnt == CW'(1)) begin
          if (pend_ok) begin
            hi_n = pend_hi;
            lo_n = pend_lo;
          end
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign busy      = (state == ST_BUSY);
  assign stall_req = D_is_mdu & (busy | start);
  assign dbg_state = state;
  assign rd_data   = (MDU_op == OP_MFHI) ? HI :
                     (MDU_op == OP_MFLO) ? LO : 32'd0;

endmodule
